mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, together with the MEM/WB pipeline register. It takes the instruction leaving EX, performs byte, halfword or word loads and stores on a word-organised data memory, and registers pc, instruction, instruction code, ALU result and load data. Those registered values feed the write-back stage directly.

## Interface
Parameters:
- DM_WORDS, 1024, data-memory depth in 32-bit words; must be a power of two.
- DM_AW, 10, word-address width; equals log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_in  in  32  pc of the instruction in MEM.
- instructure_in  in  32  raw instruction word.
- instr_code_in  in  6  decoded instruction code. Code 0 is a bubble or nop.
- alu_result_in  in  32  effective address for loads and stores; result value otherwise.
- rt_data_in  in  32  store data, already forwarded.
- stall_in  in  1  hold the MEM/WB register and suppress the store.
- flush_in  in  1  load a bubble into MEM/WB and suppress the store.
- pc_out  out  32  registered pc.
- instructure_out  out  32  registered instruction.
- instr_code_out  out  6  registered instruction code.
- alu_result_out  out  32  registered ALU result.
- mem_read_data_out  out  32  registered, extended load data.
- fwd_alu_result_out  out  32  combinational copy of alu_result_in, used by EX forwarding.

## Operation
- Access type is decoded from opcode instructure_in[31:26]:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101
  - sb 101000, sh 101001, sw 101011
  - any other opcode performs no memory access.
- Addressing:
  - Word index is alu_result_in[DM_AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DM_WORDS bytes.
  - Byte lane is alu_result_in[1:0], little-endian: lane 0 is bits [7:0].
- Alignment:
  - lw and sw ignore addr[1:0].
  - lh, lhu and sh ignore addr[0]. Half 0 is bits [15:0]; half 1 is bits [31:16].
  - No exception is raised for misaligned addresses.
- Stores:
  - sb writes rt_data_in[7:0] into the addressed byte.
  - sh writes rt_data_in[15:0] into the addressed half.
  - sw writes the full word.
  - Bytes not written are preserved.
- Loads:
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
  - Load data comes from a combinational read of the array in the current cycle.
- For non-load instructions mem_read_data_out is still the extracted word under the lw rule. The WB stage ignores it.
- Each performed store prints one simulation line: `@<pc hex>: *<byte address, word-aligned hex> <= <full resulting word hex>`.

## Timing
- Reset (rst_n=0, asynchronous):
  - all registered outputs go to 0;
  - every data-memory word goes to 0;
  - the reset is held for as long as rst_n stays low.
- Rising edge with flush_in=1, whether or not stall_in is set:
  - MEM/WB loads pc=0, instruction=0, code=0, result=0 and data=0;
  - no store occurs.
- Rising edge with stall_in=1 and flush_in=0: MEM/WB holds its value and no store occurs. The same instruction is presented again on the next cycle.
- Rising edge with both flags 0:
  - the store commits;
  - MEM/WB captures all inputs, with load data taken from the pre-edge array contents.
- Latency:
  - inputs appear on the registered outputs one cycle later;
  - a store is visible to a load issued in the next cycle.
- fwd_alu_result_out has zero latency.
- Store and load never occur in the same cycle, because one instruction occupies the stage at a time.
- If reset is asserted in the middle of a stall, the register clears and the pending store is lost.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; after release, lw from 0x0 returns 0.
- Store word then load:
  - sw of 0x12345678 to 0x10 -> print line `@<pc>: *00000010 <= 12345678`;
  - lw from 0x10 the next cycle -> mem_read_data_out=0x12345678 one cycle later.
- Byte and half merge (word 0x10 holds 0x12345678):
  - sb 0xAB to 0x13 -> word 0xAB345678;
  - lb from 0x13 -> 0xFFFFFFAB; lbu -> 0x000000AB;
  - sh 0x8001 to 0x10 -> word 0xAB348001; lh from 0x10 -> 0xFFFF8001; lhu -> 0x00008001.
- Wrap: sw 0xDEADBEEF to 0x1000 with DM_WORDS=1024 -> word 0 is modified; lw from 0x0 returns 0xDEADBEEF.
- Stall: sw asserted with stall_in=1 for 3 cycles -> outputs frozen and memory unchanged; the store commits exactly once, on the first edge with stall_in=0.
- Flush priority: sw with stall_in=1 and flush_in=1 -> no store; all outputs 0 after the edge.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM boundary, the memory stage and the MEM/WB outputs.
interface mem_stage_if;
  logic [31:0] pc_in;
  logic [31:0] instructure_in;
  logic [5:0]  instr_code_in;
  logic [31:0] alu_result_in;
  logic [31:0] rt_data_in;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] pc_out;
  logic [31:0] instructure_out;
  logic [5:0]  instr_code_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_read_data_out;
  logic [31:0] fwd_alu_result_out;

  modport master (
    output pc_in, instructure_in, instr_code_in, alu_result_in, rt_data_in,
           stall_in, flush_in,
    input  pc_out, instructure_out, instr_code_out, alu_result_out,
           mem_read_data_out, fwd_alu_result_out
  );

  modport slave (
    input  pc_in, instructure_in, instr_code_in, alu_result_in, rt_data_in,
           stall_in, flush_in,
    output pc_out, instructure_out, instr_code_out, alu_result_out,
           mem_read_data_out, fwd_alu_result_out
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte/half/word loads and stores on a word-organised
// data memory, followed by the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned DM_WORDS = 1024,
  parameter int unsigned DM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [31:0] mem_q [DM_WORDS];

  logic [31:0] pc_q, instr_q, alu_q, rdata_q;
  logic [5:0]  code_q;

  logic [5:0]       opcode;
  logic [DM_AW-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;
  logic [31:0]      wr_word;
  logic             is_store;
  logic             advance;

  assign opcode   = bus.instructure_in[31:26];
  assign word_idx = bus.alu_result_in[DM_AW+1:2];
  assign lane     = bus.alu_result_in[1:0];
  assign rd_word  = mem_q[word_idx];
  assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign advance  = !bus.stall_in && !bus.flush_in;

  // Load extraction; non-load instructions fall through to the whole word.
  always_comb begin
    load_data = rd_word;
    case (opcode)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Read-modify-write merge so unwritten bytes keep their old contents.
  always_comb begin
    wr_word  = rd_word;
    is_store = 1'b0;
    case (opcode)
      OP_SB: begin
        is_store = 1'b1;
        wr_word[{lane, 3'b000} +: 8] = bus.rt_data_in[7:0];
      end
      OP_SH: begin
        is_store = 1'b1;
        if (lane[1]) wr_word[31:16] = bus.rt_data_in[15:0];
        else         wr_word[15:0]  = bus.rt_data_in[15:0];
      end
      OP_SW: begin
        is_store = 1'b1;
        wr_word  = bus.rt_data_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (advance && is_store) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  // MEM/WB register: flush wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      code_q  <= 6'd0;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else if (bus.flush_in) begin
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      code_q  <= 6'd0;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else if (!bus.stall_in) begin
      pc_q    <= bus.pc_in;
      instr_q <= bus.instructure_in;
      code_q  <= bus.instr_code_in;
      alu_q   <= bus.alu_result_in;
      rdata_q <= load_data;
    end
  end

  assign bus.pc_out             = pc_q;
  assign bus.instructure_out    = instr_q;
  assign bus.instr_code_out     = code_q;
  assign bus.alu_result_out     = alu_q;
  assign bus.mem_read_data_out  = rdata_q;
  assign bus.fwd_alu_result_out = bus.alu_result_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a byte-addressed model.
module tb_mem_stage;

  localparam int unsigned NBYTES = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(1024), .DM_AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic [7:0]  ref_bytes [NBYTES];
  logic [31:0] exp_pc, exp_ins, exp_alu, exp_data;
  logic [5:0]  exp_code;
  logic [31:0] pc_ctr;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned base);
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < NBYTES; i++) ref_bytes[i] = 8'd0;
    exp_pc = 0; exp_ins = 0; exp_code = 0; exp_alu = 0; exp_data = 0;
  endtask

  // Behaviour of one rising edge, computed from the byte-level view of memory.
  task automatic model_edge();
    int unsigned a;
    logic [5:0]  op;
    logic [31:0] ld;
    a  = bus.alu_result_in % NBYTES;
    op = bus.instructure_in[31:26];
    if (!rst_n || bus.flush_in) begin
      if (!rst_n) ref_clear();
      else begin exp_pc = 0; exp_ins = 0; exp_code = 0; exp_alu = 0; exp_data = 0; end
    end else if (!bus.stall_in) begin
      case (op)
        LB:  ld = 32'($signed(ref_bytes[a]));
        LBU: ld = 32'(ref_bytes[a]);
        LH:  ld = 32'($signed({ref_bytes[(a & ~1) + 1], ref_bytes[a & ~1]}));
        LHU: ld = 32'({ref_bytes[(a & ~1) + 1], ref_bytes[a & ~1]});
        default: ld = ref_word(a & ~3);
      endcase
      if (op == SB) ref_bytes[a] = bus.rt_data_in[7:0];
      if (op == SH || op == SW) begin
        ref_bytes[a & ~(op == SW ? 3 : 1)]     = bus.rt_data_in[7:0];
        ref_bytes[(a & ~(op == SW ? 3 : 1)) + 1] = bus.rt_data_in[15:8];
      end
      if (op == SW) begin
        ref_bytes[(a & ~3) + 2] = bus.rt_data_in[23:16];
        ref_bytes[(a & ~3) + 3] = bus.rt_data_in[31:24];
      end
      if (op == SB || op == SH || op == SW)
        $display("@%h: *%h <= %h", bus.pc_in, 32'(a & ~3), ref_word(a & ~3));
      exp_pc = bus.pc_in; exp_ins = bus.instructure_in; exp_code = bus.instr_code_in;
      exp_alu = bus.alu_result_in; exp_data = ld;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"},   bus.pc_out, exp_pc);
    check({tag, ".ins"},  bus.instructure_out, exp_ins);
    check({tag, ".code"}, 32'(bus.instr_code_out), 32'(exp_code));
    check({tag, ".alu"},  bus.alu_result_out, exp_alu);
    check({tag, ".data"}, bus.mem_read_data_out, exp_data);
  endtask

  task automatic cycle(input string tag);
    check({tag, ".fwd"}, bus.fwd_alu_result_out, bus.alu_result_in);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic st, input logic fl);
    bus.pc_in          = pc_ctr;
    pc_ctr             = pc_ctr + 4;
    bus.instructure_in = {op, 26'($urandom)};
    bus.instr_code_in  = 6'($urandom_range(1, 63));
    bus.alu_result_in  = addr;
    bus.rt_data_in     = rt;
    bus.stall_in       = st;
    bus.flush_in       = fl;
  endtask

  task automatic op(input string tag, input logic [5:0] o, input logic [31:0] addr,
                    input logic [31:0] rt);
    drive(o, addr, rt, 1'b0, 1'b0);
    cycle(tag);
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000, 6'b001000};
    pc_ctr = 32'h0040_0000;
    ref_clear();

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(6'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      cycle("reset");
    end
    rst_n = 1'b1;
    op("lw0", LW, 32'h0, 32'h0);

    op("sw10", SW, 32'h10, 32'h1234_5678);
    op("lw10", LW, 32'h10, 32'h0);
    check("lw10.val", bus.mem_read_data_out, 32'h1234_5678);

    op("sb13",  SB,  32'h13, 32'h0000_00AB);
    op("lb13",  LB,  32'h13, 32'h0);
    check("lb13.val", bus.mem_read_data_out, 32'hFFFF_FFAB);
    op("lbu13", LBU, 32'h13, 32'h0);
    check("lbu13.val", bus.mem_read_data_out, 32'h0000_00AB);
    op("sh10",  SH,  32'h10, 32'h5555_8001);
    op("lh10",  LH,  32'h10, 32'h0);
    check("lh10.val", bus.mem_read_data_out, 32'hFFFF_8001);
    op("lhu10", LHU, 32'h10, 32'h0);
    check("lhu10.val", bus.mem_read_data_out, 32'h0000_8001);
    op("lw10b", LW,  32'h11, 32'h0);
    check("lw10b.val", bus.mem_read_data_out, 32'hAB34_8001);

    op("swwrap", SW, 32'h1000, 32'hDEAD_BEEF);
    op("lwwrap", LW, 32'h0, 32'h0);
    check("lwwrap.val", bus.mem_read_data_out, 32'hDEAD_BEEF);

    // Stalled store: frozen outputs, then exactly one commit
    drive(SW, 32'h20, 32'hCAFE_0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall");
    bus.stall_in = 1'b0;
    cycle("stallrel");
    op("lw20", LW, 32'h20, 32'h0);
    check("lw20.val", bus.mem_read_data_out, 32'hCAFE_0001);

    // Flush has priority over stall
    drive(SW, 32'h30, 32'hFFFF_FFFF, 1'b1, 1'b1);
    cycle("flush");
    op("lw30", LW, 32'h30, 32'h0);
    check("lw30.val", bus.mem_read_data_out, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(ops[$urandom_range(0, 9)],
            ($urandom_range(0, 3) << 12) | $urandom_range(0, 63),
            $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    // Reset asserted mid-stall drops the pending store
    drive(SW, 32'h40, 32'h0BAD_F00D, 1'b1, 1'b0);
    cycle("prerst");
    #2 rst_n = 1'b0;
    #1;
    ref_clear();
    check_outputs("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    op("lw40", LW, 32'h40, 32'h0);
    check("lw40.val", bus.mem_read_data_out, 32'h0);
    op("lw10c", LW, 32'h10, 32'h0);
    check("lw10c.val", bus.mem_read_data_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
